// File: rtl/aud_recorder.sv
// I2S ADC capture into SRAM: left channel words written to consecutive addresses.
// Define AUD_RECORDER_STEREO_EN to also capture the right channel (adds SHIFT_R).
module aud_recorder #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [15:0]       o_data,
  output logic              o_write,
  output logic              o_full,
  output logic              o_busy
);

  // state   | meaning
  // IDLE    | stopped, waiting for i_start
  // WAIT_L  | armed, waiting for the left word-clock edge
  // SHIFT_L | shifting in 16 left-channel bits
  // WAIT_R  | waiting for the right word-clock edge
  // SHIFT_R | shifting in 16 right-channel bits (stereo build only)
  // PAUSE   | suspended, address retained for a contiguous resume
  typedef enum logic [2:0] {
    IDLE, WAIT_L, SHIFT_L, WAIT_R, PAUSE
`ifdef AUD_RECORDER_STEREO_EN
    , SHIFT_R
`endif
  } state_t;

  state_t      state, nxt;
  logic        lrck_d;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        pend;

  logic shift_en, cnt_clr, wr_en, set_full, addr_clr, pend_set, pend_clr;
  logic left_edge, right_edge, last_bit, at_max;

  assign left_edge  = ~i_adclrck & lrck_d;
  assign right_edge = i_adclrck & ~lrck_d;
  assign last_bit   = (bit_cnt == 4'd15);
  assign at_max     = (o_address == MAX_ADDR);
  assign o_busy     = (state != IDLE) && (state != PAUSE);

  always_comb begin
    nxt      = state;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    wr_en    = 1'b0;
    set_full = 1'b0;
    addr_clr = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state)
      IDLE: begin
        if (!i_stop && !i_pause && i_start) begin
          nxt      = WAIT_L;
          addr_clr = 1'b1;
        end
      end
      WAIT_L: begin
        if (i_stop)         nxt = IDLE;
        else if (i_pause)   nxt = PAUSE;
        else if (left_edge) begin
          nxt     = SHIFT_L;
          cnt_clr = 1'b1;
        end
      end
      SHIFT_L: begin
        if (i_stop) nxt = IDLE;
        else begin
          shift_en = 1'b1;
          pend_set = i_pause;
          if (last_bit) begin
            wr_en = 1'b1;
            if (at_max) begin
              nxt      = IDLE;
              set_full = 1'b1;
            end
`ifdef AUD_RECORDER_STEREO_EN
            else nxt = WAIT_R;
`else
            else if (pend || i_pause) nxt = PAUSE;
            else nxt = WAIT_R;
`endif
          end
        end
      end
      WAIT_R: begin
        if (i_stop)          nxt = IDLE;
        else if (i_pause)    nxt = PAUSE;
        else if (right_edge) begin
`ifdef AUD_RECORDER_STEREO_EN
          nxt     = SHIFT_R;
          cnt_clr = 1'b1;
`else
          nxt = WAIT_L;
`endif
        end
      end
`ifdef AUD_RECORDER_STEREO_EN
      SHIFT_R: begin
        if (i_stop) nxt = IDLE;
        else begin
          shift_en = 1'b1;
          pend_set = i_pause;
          if (last_bit) begin
            wr_en = 1'b1;
            if (at_max) begin
              nxt      = IDLE;
              set_full = 1'b1;
            end
            else if (pend || i_pause) nxt = PAUSE;
            else nxt = WAIT_L;
          end
        end
      end
`endif
      PAUSE: begin
        if (i_stop)                     nxt = IDLE;
        else if (!i_pause && i_start)   nxt = WAIT_L;
      end
      default: nxt = IDLE;
    endcase
    // A pause request only survives while the word it was raised in is in flight.
    if (nxt == IDLE || nxt == PAUSE) pend_clr = 1'b1;
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state     <= IDLE;
      lrck_d    <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      pend      <= 1'b0;
      o_address <= '0;
      o_data    <= '0;
      o_write   <= 1'b0;
      o_full    <= 1'b0;
    end else begin
      state   <= nxt;
      lrck_d  <= i_adclrck;
      o_write <= wr_en;
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) shreg  <= {shreg[14:0], i_adcdat};
      if (wr_en)    o_data <= {shreg[14:0], i_adcdat};
      // o_full goes high together with the write at MAX_ADDR, which blocks that increment.
      if (addr_clr) begin
        o_address <= '0;
        o_full    <= 1'b0;
      end else begin
        if (o_write && !o_full) o_address <= o_address + 1'b1;
        if (set_full)           o_full    <= 1'b1;
      end
      if (pend_clr)      pend <= 1'b0;
      else if (pend_set) pend <= 1'b1;
    end
  end

endmodule
